// File: rtl/cp0_vic_if.sv
// Datapath <-> CP0 vectored interrupt controller bus.
// The master side is the pipeline; the slave side is cp0_vic.
interface cp0_vic_if #(
  parameter int IRQ_N = 4
);
  logic [1:0]       oper;
  logic [4:0]       addr_r;
  logic [31:0]      data_r;
  logic [4:0]       addr_w;
  logic [31:0]      data_w;
  logic             ir_en;
  logic [IRQ_N-1:0] ir_in;
  logic [31:0]      ret_addr;
  logic             ir;
  logic             ir_valid;
  logic             ir_wait;
  logic             jump_en;
  logic [31:0]      jump_addr;

  modport master (
    output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    input  data_r, ir, ir_valid, ir_wait, jump_en, jump_addr
  );

  modport slave (
    input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
    output data_r, ir, ir_valid, ir_wait, jump_en, jump_addr
  );
endinterface

// File: rtl/cp0_vic.sv
// CP0 vectored interrupt controller: IRQ latch/mask/priority, EPC save/restore, MFC0/MTC0/ERET.
// Optional nested preemption with an EPC/CUR stack is enabled by defining CP0_NESTED_EN.
module cp0_vic #(
  parameter int          IRQ_N       = 4,
  parameter int          VEC_SHIFT   = 4,
  parameter logic [31:0] RESET_VBASE = 32'h0000_0100,
  parameter int          NEST_DEPTH  = 2
) (
  input  logic      clk,
  input  logic      rst,
  cp0_vic_if.slave  bus
);

  localparam logic [31:0] VBASE_MASK = ~((32'd1 << (VEC_SHIFT + 3)) - 32'd1);

  typedef enum logic {S_IDLE = 1'b0, S_ISR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             ie_q, ie_d;
  logic [IRQ_N-1:0] im_q, im_d;
  logic [IRQ_N-1:0] ip_q, ip_d;
  logic [2:0]       cur_q, cur_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      vbase_q, vbase_d;
  logic [IRQ_N-1:0] ir_sync_q, ir_prev_q;

  logic [IRQ_N-1:0] rise, pend, sel_oh;
  logic [2:0]       sel;
  logic             any_pend, ir_req, take, is_mtc0, is_eret;

`ifdef CP0_NESTED_EN
  logic [31:0] stk_epc_q [0:3];
  logic [2:0]  stk_cur_q [0:3];
  logic [2:0]  depth_q, depth_d;
  logic        push, pop;
  logic [1:0]  top_idx;
`endif

  assign is_mtc0 = (bus.oper == 2'b10);
  assign is_eret = (bus.oper == 2'b11);

  // A request is a rising edge of the once-registered input level.
  genvar gi;
  generate
    for (gi = 0; gi < IRQ_N; gi++) begin : g_ch
      assign rise[gi] = ir_sync_q[gi] & ~ir_prev_q[gi];
      assign pend[gi] = ip_q[gi] & im_q[gi];
    end
  endgenerate

  assign any_pend = |pend;

  always_comb begin
    sel    = 3'd0;
    sel_oh = '0;
    for (int k = IRQ_N - 1; k >= 0; k--) begin
      if (pend[k]) begin
        sel       = 3'(k);
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    ir_req = 1'b0;
    if (state_q == S_IDLE) begin
      ir_req = any_pend & ie_q;
    end
`ifdef CP0_NESTED_EN
    else begin
      ir_req = any_pend & ie_q & (sel < cur_q) & (depth_q < 3'(NEST_DEPTH));
    end
`endif
  end

  // ERET owns the jump port this cycle; entry is retried next cycle.
  assign take = ir_req & bus.ir_en & ~is_eret;

`ifdef CP0_NESTED_EN
  assign push    = take & (state_q == S_ISR);
  assign pop     = is_eret & (state_q == S_ISR) & (depth_q != 3'd0);
  assign top_idx = 2'(depth_q - 3'd1);
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take) state_d = S_ISR;
      end
      S_ISR: begin
`ifdef CP0_NESTED_EN
        if (is_eret && depth_q == 3'd0) state_d = S_IDLE;
`else
        if (is_eret) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.ir        = ir_req;
    bus.ir_valid  = (state_q == S_ISR);
    bus.ir_wait   = ir_req & ~bus.ir_en;
    bus.jump_en   = take | is_eret;
    bus.jump_addr = '0;
    if (take) begin
      bus.jump_addr = vbase_q + (32'(sel) << VEC_SHIFT);
    end else if (is_eret) begin
      bus.jump_addr = epc_q;
    end
  end

  always_comb begin
    bus.data_r = '0;
    case (bus.addr_r)
      5'd0: begin
        bus.data_r[0]           = ie_q;
        bus.data_r[IRQ_N+7:8]   = im_q;
      end
      5'd1: begin
        bus.data_r[18:16]       = cur_q;
        bus.data_r[IRQ_N-1:0]   = ip_q;
      end
      5'd2:    bus.data_r = epc_q;
      5'd3:    bus.data_r = vbase_q;
      default: bus.data_r = '0;
    endcase
  end

  // Software writes first, then ERET, then hardware entry, so entry overrides MTC0.
  always_comb begin
    ie_d    = ie_q;
    im_d    = im_q;
    ip_d    = ip_q;
    cur_d   = cur_q;
    epc_d   = epc_q;
    vbase_d = vbase_q;
`ifdef CP0_NESTED_EN
    depth_d = depth_q;
`endif
    if (is_mtc0) begin
      case (bus.addr_w)
        5'd0: begin
          ie_d = bus.data_w[0];
          im_d = bus.data_w[IRQ_N+7:8];
        end
        5'd1:    ip_d    = ip_q & ~bus.data_w[IRQ_N-1:0];
        5'd2:    epc_d   = bus.data_w;
        5'd3:    vbase_d = bus.data_w & VBASE_MASK;
        default: ;
      endcase
    end
    if (is_eret && state_q == S_ISR) begin
      ie_d = 1'b1;
`ifdef CP0_NESTED_EN
      if (pop) begin
        epc_d   = stk_epc_q[top_idx];
        cur_d   = stk_cur_q[top_idx];
        depth_d = depth_q - 3'd1;
      end
`endif
    end
    if (take) begin
      epc_d = bus.ret_addr;
      ip_d  = ip_d & ~sel_oh;
      cur_d = sel;
      ie_d  = 1'b0;
`ifdef CP0_NESTED_EN
      if (push) depth_d = depth_q + 3'd1;
`endif
    end
    ip_d = ip_d | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q      <= 1'b0;
      im_q      <= '0;
      ip_q      <= '0;
      cur_q     <= 3'd0;
      epc_q     <= '0;
      vbase_q   <= RESET_VBASE & VBASE_MASK;
      ir_sync_q <= '0;
      ir_prev_q <= '0;
    end else begin
      ie_q      <= ie_d;
      im_q      <= im_d;
      ip_q      <= ip_d;
      cur_q     <= cur_d;
      epc_q     <= epc_d;
      vbase_q   <= vbase_d;
      ir_sync_q <= bus.ir_in;
      ir_prev_q <= ir_sync_q;
    end
  end

`ifdef CP0_NESTED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= 3'd0;
      for (int k = 0; k < 4; k++) begin
        stk_epc_q[k] <= '0;
        stk_cur_q[k] <= 3'd0;
      end
    end else begin
      depth_q <= depth_d;
      if (push) begin
        stk_epc_q[depth_q[1:0]] <= epc_q;
        stk_cur_q[depth_q[1:0]] <= cur_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cp0_vic.sv
// Scoreboard bench for cp0_vic: expected jumps and MFC0 reads are queued, a negedge monitor checks them.
module tb_cp0_vic;
  localparam int IRQ_N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_vic_if #(.IRQ_N(IRQ_N)) bus ();

  cp0_vic #(
    .IRQ_N(IRQ_N), .VEC_SHIFT(4), .RESET_VBASE(32'h0000_0100), .NEST_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] jmp_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  logic        rd_active = 1'b0;

  // Monitor: every jump and every flagged MFC0 cycle consumes one expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    string       nm;
    if (!rst && bus.jump_en) begin
      n_cmp++;
      if (jmp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_jump: got jump_addr=0x%08h, required no jump", bus.jump_addr);
      end else begin
        e = jmp_q.pop_front();
        if (bus.jump_addr !== e) begin
          n_bad++;
          $display("FAIL jump: got 0x%08h, required 0x%08h", bus.jump_addr, e);
        end else begin
          $display("jump 0x%08h ok", bus.jump_addr);
        end
      end
    end
    if (rd_active && rd_q.size() != 0) begin
      e  = rd_q.pop_front();
      nm = rd_name_q.pop_front();
      n_cmp++;
      if (bus.data_r !== e) begin
        n_bad++;
        $display("FAIL mfc0_%s: got 0x%08h, required 0x%08h", nm, bus.data_r, e);
      end else begin
        $display("mfc0 %s = 0x%08h ok", nm, bus.data_r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end else begin
      $display("check %s = 0x%0h ok", nm, act);
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.oper   = 2'b10;
    bus.addr_w = a;
    bus.data_w = d;
    tick();
    bus.oper   = 2'b00;
  endtask

  task automatic mfc0(input string nm, input logic [4:0] a, input logic [31:0] req);
    bus.oper    = 2'b01;
    bus.addr_r  = a;
    rd_q.push_back(req);
    rd_name_q.push_back(nm);
    rd_active   = 1'b1;
    tick();
    rd_active   = 1'b0;
    bus.oper    = 2'b00;
  endtask

  task automatic eret();
    bus.oper = 2'b11;
    tick();
    bus.oper = 2'b00;
  endtask

  task automatic pulse(input logic [IRQ_N-1:0] m);
    bus.ir_in = m;
    tick();
    bus.ir_in = '0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && jmp_q.size() != 0; i++) tick();
    if (jmp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_%s: got %0d jumps outstanding, required 0", nm, jmp_q.size());
      jmp_q.delete();
    end
  endtask

  initial begin
    bus.oper     = 2'b00;
    bus.addr_r   = 5'd0;
    bus.addr_w   = 5'd0;
    bus.data_w   = '0;
    bus.ir_en    = 1'b1;
    bus.ir_in    = '0;
    bus.ret_addr = 32'h40;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ir", {31'd0, bus.ir}, 0);
    chk("rst_ir_valid", {31'd0, bus.ir_valid}, 0);
    chk("rst_ir_wait", {31'd0, bus.ir_wait}, 0);
    chk("rst_jump_en", {31'd0, bus.jump_en}, 0);
    mfc0("rst_status", 5'd0, 32'h0);
    mfc0("rst_cause", 5'd1, 32'h0);
    mfc0("rst_epc", 5'd2, 32'h0);
    mfc0("rst_vbase", 5'd3, 32'h100);
    mfc0("unmapped", 5'd7, 32'h0);
    mtc0(5'd3, 32'h0000_02FF);
    mfc0("vbase_lowbits", 5'd3, 32'h280);

    // 1: basic entry on ch2
    mtc0(5'd0, 32'h0F01);
    mtc0(5'd3, 32'h200);
    jmp_q.push_back(32'h220);
    pulse(4'b0100);
    drain("t1");
    mfc0("t1_epc", 5'd2, 32'h40);
    mfc0("t1_cause", 5'd1, 32'h0002_0000);
    mfc0("t1_status", 5'd0, 32'h0F00);
    chk("t1_ir_valid", {31'd0, bus.ir_valid}, 1);
    jmp_q.push_back(32'h40);
    eret();
    drain("t1_eret");
    chk("t1_idle", {31'd0, bus.ir_valid}, 0);

    // 2: ch3 and ch1 together, lowest index first
    bus.ret_addr = 32'h80;
    jmp_q.push_back(32'h210);
    pulse(4'b1010);
    drain("t2a");
    mfc0("t2_cause", 5'd1, 32'h0001_0008);
    jmp_q.push_back(32'h80);
    jmp_q.push_back(32'h230);
    eret();
    drain("t2b");
    mfc0("t2_cause_ch3", 5'd1, 32'h0003_0000);

    // 3: ERET while a new request is pending; ERET jumps first, IE=1 before entry
    bus.ret_addr = 32'hC0;
    pulse(4'b0001);
    tick();
    chk("t3_ir_in_isr", {31'd0, bus.ir}, 0);
    jmp_q.push_back(32'h80);
    jmp_q.push_back(32'h200);
    eret();
    mfc0("t3_status_ie", 5'd0, 32'h0F01);
    drain("t3");
    mfc0("t3_epc", 5'd2, 32'hC0);

    // 4: held by ir_en=0, then entry beats a same-cycle STATUS write
    jmp_q.push_back(32'hC0);
    eret();
    drain("t4_eret");
    bus.ir_en = 1'b0;
    pulse(4'b0010);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_ir_hold", {31'd0, bus.ir}, 1);
      chk("t4_ir_wait", {31'd0, bus.ir_wait}, 1);
      tick();
    end
    jmp_q.push_back(32'h210);
    bus.ir_en = 1'b1;
    mtc0(5'd0, 32'h0F01);
    drain("t4");
    mfc0("t4_status_hw_wins", 5'd0, 32'h0F00);
    chk("t4_ir_wait_clear", {31'd0, bus.ir_wait}, 0);
    jmp_q.push_back(32'hC0);
    eret();
    drain("t4_eret2");

    // 5: W1C in the same cycle as the IP set; masked channel raises no ir
    mtc0(5'd0, 32'h0B01);
    bus.ir_in = 4'b0100;
    tick();
    bus.ir_in = '0;
    mtc0(5'd1, 32'h4);
    mfc0("t5_cause_set_wins", 5'd1, 32'h0001_0004);
    chk("t5_ir_masked", {31'd0, bus.ir}, 0);
    mtc0(5'd1, 32'h4);
    mfc0("t5_cause_cleared", 5'd1, 32'h0001_0000);

    // 6: ch3 handler, IE re-enabled, ch0 raised
    mtc0(5'd0, 32'h0F01);
    bus.ret_addr = 32'h300;
    jmp_q.push_back(32'h230);
    pulse(4'b1000);
    drain("t6_ch3");
    mtc0(5'd0, 32'h0F01);
    bus.ret_addr = 32'h340;
`ifdef CP0_NESTED_EN
    jmp_q.push_back(32'h200);
    pulse(4'b0001);
    drain("t6_preempt");
    mfc0("t6_epc_inner", 5'd2, 32'h340);
    jmp_q.push_back(32'h340);
    eret();
    drain("t6_pop");
    mfc0("t6_cause_pop", 5'd1, 32'h0003_0000);
    mfc0("t6_epc_pop", 5'd2, 32'h300);
    chk("t6_still_isr", {31'd0, bus.ir_valid}, 1);
    jmp_q.push_back(32'h300);
    eret();
    drain("t6_last");
    chk("t6_idle", {31'd0, bus.ir_valid}, 0);
`else
    pulse(4'b0001);
    tick();
    chk("t6_no_preempt", {31'd0, bus.ir}, 0);
    jmp_q.push_back(32'h300);
    jmp_q.push_back(32'h200);
    eret();
    drain("t6_after_eret");
    jmp_q.push_back(32'h340);
    eret();
    drain("t6_last");
    chk("t6_idle", {31'd0, bus.ir_valid}, 0);
`endif

    // 7: reset in the middle of a handler
    bus.ret_addr = 32'h380;
    jmp_q.push_back(32'h210);
    pulse(4'b0010);
    drain("t7");
    chk("t7_in_isr", {31'd0, bus.ir_valid}, 1);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("t7_rst_ir_valid", {31'd0, bus.ir_valid}, 0);
    mfc0("t7_rst_epc", 5'd2, 32'h0);
    mfc0("t7_rst_status", 5'd0, 32'h0);
    mfc0("t7_rst_vbase", 5'd3, 32'h100);
    repeat (3) tick();

    if (jmp_q.size() != 0 || rd_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d jumps, %0d reads outstanding, required 0", jmp_q.size(), rd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
